// File: rtl/decode_hazard_ctrl_if.sv
// Decode/execute-side signal bundle for the hazard controller.
// master = pipeline (drives decode/execute status), slave = hazard controller.
interface decode_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic             id_rs1_re;
  logic [4:0]       id_rs2;
  logic             id_rs2_re;
  logic [4:0]       id_rd;
  logic             id_rd_we;
  logic             id_is_div;
  logic             ex_load;
  logic [4:0]       ex_dst;
  logic             ex_branch_flush;
  logic             div_done;
  logic [4:0]       div_dst;
  logic             if_stall;
  logic             id_bubble;
  logic             if_flush;
  logic             id_flush;
  logic             id_issue;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs1_re, id_rs2, id_rs2_re, id_rd, id_rd_we, id_is_div,
           ex_load, ex_dst, ex_branch_flush, div_done, div_dst,
    input  if_stall, id_bubble, if_flush, id_flush, id_issue, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_re, id_rs2, id_rs2_re, id_rd, id_rd_we, id_is_div,
           ex_load, ex_dst, ex_branch_flush, div_done, div_dst,
    output if_stall, id_bubble, if_flush, id_flush, id_issue, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Front-end hazard controller: divide scoreboard, load-use and structural stalls,
// branch-flush window sequencing and saturating stall/flush counters.
module decode_hazard_ctrl #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  decode_hazard_ctrl_if.slave hz
);

  typedef enum logic {StRun, StFlush} state_e;

  localparam logic [3:0]       Reload = 4'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q;
  logic [3:0]       fcnt_q;
  logic [31:0]      sb_q, sb_d, sb_clr, sb_eff;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic is_run, raw_sb, ld_use, struct_haz, stall, issue;

  // A bit being retired this cycle is already bypassed to decode.
  always_comb begin
    sb_clr = '0;
    if (hz.div_done) sb_clr[hz.div_dst] = 1'b1;
    sb_eff = sb_q & ~sb_clr;
  end

  assign is_run     = (state_q == StRun);
  assign raw_sb     = (hz.id_rs1_re && (hz.id_rs1 != 5'd0) && sb_eff[hz.id_rs1]) ||
                      (hz.id_rs2_re && (hz.id_rs2 != 5'd0) && sb_eff[hz.id_rs2]) ||
                      (hz.id_rd_we  && (hz.id_rd  != 5'd0) && sb_eff[hz.id_rd]);
  assign ld_use     = hz.ex_load && (hz.ex_dst != 5'd0) &&
                      ((hz.id_rs1_re && (hz.ex_dst == hz.id_rs1)) ||
                       (hz.id_rs2_re && (hz.ex_dst == hz.id_rs2)));
  assign struct_haz = hz.id_is_div && busy_q && !hz.div_done;
  assign stall      = hz.id_valid && is_run && !hz.ex_branch_flush &&
                      (raw_sb || ld_use || struct_haz);
  assign issue      = hz.id_valid && is_run && !stall && !hz.ex_branch_flush;

  assign hz.if_stall  = stall;
  assign hz.id_bubble = stall;
  assign hz.if_flush  = !is_run || hz.ex_branch_flush;
  assign hz.id_flush  = !is_run || hz.ex_branch_flush;
  assign hz.id_issue  = issue;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

  // Set after clear so a new divide claiming a just-retired register wins.
  always_comb begin
    sb_d   = sb_q & ~sb_clr;
    busy_d = busy_q;
    if (hz.div_done) busy_d = 1'b0;
    if (issue && hz.id_is_div) begin
      busy_d = 1'b1;
      if (hz.id_rd_we && (hz.id_rd != 5'd0)) sb_d[hz.id_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      fcnt_q      <= '0;
      sb_q        <= '0;
      busy_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz.ex_branch_flush) begin
            state_q <= StFlush;
            fcnt_q  <= Reload;
          end
        end
        StFlush: begin
          if (hz.ex_branch_flush) begin
            fcnt_q <= Reload;
          end else if (fcnt_q == 4'd0) begin
            state_q <= StRun;
          end else begin
            fcnt_q <= fcnt_q - 4'd1;
          end
        end
        default: state_q <= StRun;
      endcase
      sb_q   <= sb_d;
      busy_q <= busy_d;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CntOne;
      if (!is_run && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CntOne;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: cycle-level model plus directed scenarios.
module tb_decode_hazard_ctrl;

  localparam int unsigned TbFlush = 2;
  localparam int unsigned TbCntW  = 4;
  localparam int          SatMax  = (1 << TbCntW) - 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  decode_hazard_ctrl_if #(.CNT_W(TbCntW)) hz ();

  decode_hazard_ctrl #(
    .FLUSH_CYC(TbFlush),
    .CNT_W    (TbCntW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pending divide destinations, divider occupancy,
  // remaining cycles of the flush window and event tallies.
  bit sb_m [32];
  bit busy_m;
  int fl_left;
  int stall_n;
  int flush_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending(input bit en, input logic [4:0] r);
    return en && (r != 5'd0) && sb_m[r] && !(hz.div_done && (hz.div_dst == r));
  endfunction

  // Returns {stall, flush, issue} as the rules require for the current inputs.
  function automatic logic [2:0] expect_now();
    bit run, haz, st;
    run = (fl_left == 0);
    haz = pending(hz.id_rs1_re, hz.id_rs1) || pending(hz.id_rs2_re, hz.id_rs2) ||
          pending(hz.id_rd_we, hz.id_rd) ||
          (hz.ex_load && (hz.ex_dst != 5'd0) &&
           ((hz.id_rs1_re && (hz.ex_dst == hz.id_rs1)) ||
            (hz.id_rs2_re && (hz.ex_dst == hz.id_rs2)))) ||
          (hz.id_is_div && busy_m && !hz.div_done);
    st  = hz.id_valid && run && !hz.ex_branch_flush && haz;
    return {st, !run || hz.ex_branch_flush, hz.id_valid && run && !st && !hz.ex_branch_flush};
  endfunction

  always @(posedge clk) begin
    logic [2:0] e;
    e = expect_now();
    if (rst) begin
      for (int i = 0; i < 32; i++) sb_m[i] = 1'b0;
      busy_m  = 1'b0;
      fl_left = 0;
      stall_n = 0;
      flush_n = 0;
    end else begin
      if (e[2] && stall_n < SatMax) stall_n++;
      if (fl_left > 0 && flush_n < SatMax) flush_n++;
      if (hz.ex_branch_flush) fl_left = TbFlush;
      else if (fl_left > 0) fl_left--;
      if (hz.div_done) begin
        sb_m[hz.div_dst] = 1'b0;
        busy_m = 1'b0;
      end
      if (e[0] && hz.id_is_div) begin
        busy_m = 1'b1;
        if (hz.id_rd_we && hz.id_rd != 5'd0) sb_m[hz.id_rd] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    #2;
    if (!rst) begin
      e = expect_now();
      check("if_stall",  64'(hz.if_stall),  64'(e[2]));
      check("id_bubble", 64'(hz.id_bubble), 64'(e[2]));
      check("if_flush",  64'(hz.if_flush),  64'(e[1]));
      check("id_flush",  64'(hz.id_flush),  64'(e[1]));
      check("id_issue",  64'(hz.id_issue),  64'(e[0]));
      check("stall_cnt", 64'(hz.stall_cnt), 64'(stall_n));
      check("flush_cnt", 64'(hz.flush_cnt), 64'(flush_n));
    end
  end

  task automatic idle();
    hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs1_re = 0; hz.id_rs2 = 0; hz.id_rs2_re = 0;
    hz.id_rd = 0; hz.id_rd_we = 0; hz.id_is_div = 0; hz.ex_load = 0; hz.ex_dst = 0;
    hz.ex_branch_flush = 0; hz.div_done = 0; hz.div_dst = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic div_op(input logic [4:0] rd);
    idle();
    hz.id_valid = 1; hz.id_is_div = 1; hz.id_rd = rd; hz.id_rd_we = 1;
  endtask

  task automatic rd_op(input logic [4:0] rs1, input logic [4:0] rs2);
    idle();
    hz.id_valid = 1; hz.id_rs1 = rs1; hz.id_rs1_re = 1; hz.id_rs2 = rs2; hz.id_rs2_re = 1;
  endtask

  initial begin
    int nf;
    n_cmp = 0;
    n_bad = 0;
    idle();
    do_reset();

    // Reset state.
    #3;
    check("rst_stall", 64'(hz.if_stall), 64'd0);
    check("rst_flush", 64'(hz.if_flush), 64'd0);
    check("rst_issue", 64'(hz.id_issue), 64'd0);
    check("rst_scnt",  64'(hz.stall_cnt), 64'd0);

    // Load-use on rs2.
    tick();
    rd_op(5'd1, 5'd5);
    hz.ex_load = 1; hz.ex_dst = 5'd5;
    #3;
    check("lu_stall", 64'(hz.if_stall), 64'd1);
    check("lu_issue", 64'(hz.id_issue), 64'd0);
    tick();
    idle();
    #3;
    check("lu_cnt",   64'(hz.stall_cnt), 64'd1);
    check("lu_clear", 64'(hz.if_stall), 64'd0);
    tick();
    rd_op(5'd0, 5'd0);
    hz.ex_load = 1; hz.ex_dst = 5'd0;
    #3;
    check("lu_x0", 64'(hz.if_stall), 64'd0);

    // Divide RAW with bypass on the retiring cycle.
    tick();
    div_op(5'd7);
    #3;
    check("div_issue", 64'(hz.id_issue), 64'd1);
    tick();
    rd_op(5'd7, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #3;
      check("raw_stall", 64'(hz.if_stall), 64'd1);
      tick();
    end
    hz.div_done = 1; hz.div_dst = 5'd7;
    #3;
    check("bypass_stall", 64'(hz.if_stall), 64'd0);
    check("bypass_issue", 64'(hz.id_issue), 64'd1);
    tick();
    rd_op(5'd7, 5'd7);
    #3;
    check("sb7_clear", 64'(hz.if_stall), 64'd0);

    // Structural hazard, then retire and issue in the same cycle.
    tick();
    div_op(5'd9);
    tick();
    div_op(5'd10);
    #3;
    check("struct_stall", 64'(hz.if_stall), 64'd1);
    tick();
    hz.div_done = 1; hz.div_dst = 5'd9;
    #3;
    check("struct_issue", 64'(hz.id_issue), 64'd1);
    tick();
    div_op(5'd11);
    #3;
    check("busy_kept", 64'(hz.if_stall), 64'd1);
    tick();
    rd_op(5'd3, 5'd10);
    #3;
    check("sb10_set", 64'(hz.if_stall), 64'd1);
    tick();
    idle();
    hz.div_done = 1; hz.div_dst = 5'd10;
    tick();

    // Single flush pulse, with a load-use hazard that must be suppressed.
    do_reset();
    rd_op(5'd4, 5'd0);
    hz.ex_load = 1; hz.ex_dst = 5'd4; hz.ex_branch_flush = 1;
    #3;
    check("br_flush", 64'(hz.if_flush), 64'd1);
    check("br_nostall", 64'(hz.if_stall), 64'd0);
    tick();
    rd_op(5'd1, 5'd2);
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      #3;
      if (hz.if_flush) begin
        nf++;
        check("fl_issue", 64'(hz.id_issue), 64'd0);
      end
      tick();
    end
    check("fl_len", 64'(nf), 64'd2);
    check("fl_cnt", 64'(hz.flush_cnt), 64'd2);

    // Second flush during the window extends it.
    do_reset();
    hz.ex_branch_flush = 1;
    tick();
    nf = 0;
    for (int i = 0; i < 7; i++) begin
      hz.ex_branch_flush = (i == 0);
      #3;
      if (hz.if_flush) nf++;
      tick();
    end
    check("fl2_len", 64'(nf), 64'd3);
    check("fl2_cnt", 64'(hz.flush_cnt), 64'd3);

    // Reset asserted mid-flush with an outstanding divide.
    div_op(5'd3);
    tick();
    idle();
    hz.ex_branch_flush = 1;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    check("mrst_flush", 64'(hz.if_flush), 64'd0);
    check("mrst_fcnt",  64'(hz.flush_cnt), 64'd0);
    check("mrst_scnt",  64'(hz.stall_cnt), 64'd0);
    tick();
    rd_op(5'd3, 5'd0);
    hz.id_is_div = 1;
    #3;
    check("mrst_sb", 64'(hz.id_issue), 64'd1);

    // Stall counter saturation.
    tick();
    do_reset();
    rd_op(5'd6, 5'd0);
    hz.ex_load = 1; hz.ex_dst = 5'd6;
    repeat (20) tick();
    idle();
    #3;
    check("sat_cnt", 64'(hz.stall_cnt), 64'(SatMax));
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
